enc_packer: RTL and testbench

ENC_PACKER -- requirements
Module: enc_packer

---
 rtl/enc_packer.sv | 122 ++++++++++++
 tb/tb_enc_packer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_packer.sv
// Packs a stream of encoded bytes little-endian into 32-bit words and
// queues them in a first-word-fall-through FIFO with keep/last sideband.
module enc_packer #(
    parameter int SYMBOL_WIDTH = 8,
    parameter int DEPTH        = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    input  logic [SYMBOL_WIDTH-1:0]   enc_i,
    input  logic                      flush_i,
    input  logic                      m_ready_i,
    output logic                      m_valid_o,
    output logic [4*SYMBOL_WIDTH-1:0] m_data_o,
    output logic [3:0]                m_keep_o,
    output logic                      m_last_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      overflow_o
);

    localparam int W  = SYMBOL_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [1:0]     r_lane;
    logic [4*W-1:0] r_stage;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;
    logic           r_overflow;

    logic [4*W-1:0] r_mem_data [DEPTH];
    logic [3:0]     r_mem_keep [DEPTH];
    logic           r_mem_last [DEPTH];

    logic [4*W-1:0] w_fill;
    logic [2:0]     w_cnt;
    logic [3:0]     w_keep;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_wr;

    always_comb begin
        w_fill = r_stage;
        if (valid_i) begin
            w_fill[r_lane*W +: W] = enc_i;
        end
    end

    // Number of lanes occupied once this cycle's byte (if any) is included
    assign w_cnt = {1'b0, r_lane} + {2'b00, valid_i};

    always_comb begin
        w_keep = 4'b1111;
        if (flush_i) begin
            case (w_cnt)
                3'd0:    w_keep = 4'b0000;
                3'd1:    w_keep = 4'b0001;
                3'd2:    w_keep = 4'b0011;
                3'd3:    w_keep = 4'b0111;
                default: w_keep = 4'b1111;
            endcase
        end
    end

    assign w_push    = flush_i || (valid_i && (r_lane == 2'd3));
    assign m_valid_o = (r_level != '0);
    assign w_pop     = m_valid_o && m_ready_i;
    assign w_full    = (r_level == LW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign w_wr      = w_push && (!w_full || w_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lane  <= 2'd0;
            r_stage <= '0;
        end else if (w_push) begin
            r_lane  <= 2'd0;
            r_stage <= '0;
        end else if (valid_i) begin
            r_lane  <= r_lane + 2'd1;
            r_stage <= w_fill;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + LW'(w_wr) - LW'(w_pop);
            if (w_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem_data[r_wr_ptr] <= w_fill;
            r_mem_keep[r_wr_ptr] <= w_keep;
            r_mem_last[r_wr_ptr] <= flush_i;
        end
    end

    // Head is masked when empty so stale or uninitialised entries never show
    assign m_data_o   = m_valid_o ? r_mem_data[r_rd_ptr] : '0;
    assign m_keep_o   = m_valid_o ? r_mem_keep[r_rd_ptr] : 4'b0000;
    assign m_last_o   = m_valid_o ? r_mem_last[r_rd_ptr] : 1'b0;
    assign level_o    = r_level;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_enc_packer.sv
// Directed bench for enc_packer: packing, flush cases, FIFO full/overflow,
// and asynchronous reset behaviour.
module tb_enc_packer;

    localparam int DEPTH = 8;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic [7:0]  enc_i;
    logic        flush_i;
    logic        m_ready_i;
    logic        m_valid_o;
    logic [31:0] m_data_o;
    logic [3:0]  m_keep_o;
    logic        m_last_o;
    logic [3:0]  level_o;
    logic        overflow_o;

    int tests;
    int fails;

    enc_packer #(.SYMBOL_WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .enc_i      (enc_i),
        .flush_i    (flush_i),
        .m_ready_i  (m_ready_i),
        .m_valid_o  (m_valid_o),
        .m_data_o   (m_data_o),
        .m_keep_o   (m_keep_o),
        .m_last_o   (m_last_o),
        .level_o    (level_o),
        .overflow_o (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] wbyte(input int n, input int k);
        return 8'((n * 4 + k + 1) & 8'hFF);
    endfunction

    function automatic logic [31:0] wdata(input int n);
        return {wbyte(n, 3), wbyte(n, 2), wbyte(n, 1), wbyte(n, 0)};
    endfunction

    task automatic send(input logic [7:0] b);
        valid_i = 1'b1;
        enc_i   = b;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic push_word(input int n);
        for (int k = 0; k < 4; k++) begin
            send(wbyte(n, k));
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_i     = 1'b1;
        valid_i   = 1'b0;
        enc_i     = 8'h00;
        flush_i   = 1'b0;
        m_ready_i = 1'b0;

        #2;
        chk("rst_valid", 32'(m_valid_o), 32'd0);
        chk("rst_data", m_data_o, 32'd0);
        chk("rst_keep", 32'(m_keep_o), 32'd0);
        chk("rst_last", 32'(m_last_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        tick();
        tick();
        rst_i = 1'b0;

        // four bytes with ready high
        m_ready_i = 1'b1;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        chk("w1_valid", 32'(m_valid_o), 32'd1);
        chk("w1_data", m_data_o, 32'h44332211);
        chk("w1_keep", 32'(m_keep_o), 32'hF);
        chk("w1_last", 32'(m_last_o), 32'd0);
        tick();
        chk("w1_popped", 32'(m_valid_o), 32'd0);
        chk("w1_level", 32'(level_o), 32'd0);

        // partial word then lone flush
        m_ready_i = 1'b0;
        send(8'hAA);
        send(8'hBB);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_data", m_data_o, 32'h0000BBAA);
        chk("fl_keep", 32'(m_keep_o), 32'h3);
        chk("fl_last", 32'(m_last_o), 32'd1);
        chk("fl_level", 32'(level_o), 32'd1);
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        chk("lane0_data", m_data_o, 32'h04030201);
        chk("lane0_keep", 32'(m_keep_o), 32'hF);
        chk("lane0_last", 32'(m_last_o), 32'd0);
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        chk("lane0_pop", 32'(level_o), 32'd0);

        // flush with 4th byte, then empty-flush marker
        send(8'h12);
        send(8'h34);
        send(8'h56);
        flush_i = 1'b1;
        send(8'h55);
        tick();
        flush_i = 1'b0;
        chk("f4_level", 32'(level_o), 32'd2);
        chk("f4_data", m_data_o, 32'h55563412);
        chk("f4_keep", 32'(m_keep_o), 32'hF);
        chk("f4_last", 32'(m_last_o), 32'd1);
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        chk("mk_data", m_data_o, 32'd0);
        chk("mk_keep", 32'(m_keep_o), 32'h0);
        chk("mk_last", 32'(m_last_o), 32'd1);
        chk("mk_valid", 32'(m_valid_o), 32'd1);
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;

        // single byte with flush on lane 0
        flush_i = 1'b1;
        send(8'h77);
        flush_i = 1'b0;
        chk("f1_data", m_data_o, 32'h00000077);
        chk("f1_keep", 32'(m_keep_o), 32'h1);
        chk("f1_last", 32'(m_last_o), 32'd1);
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        chk("f1_empty", 32'(level_o), 32'd0);

        // overflow: DEPTH+1 words with no ready
        for (int n = 0; n <= DEPTH; n++) begin
            push_word(n);
        end
        chk("of_level", 32'(level_o), 32'(DEPTH));
        chk("of_flag", 32'(overflow_o), 32'd1);
        m_ready_i = 1'b1;
        for (int n = 0; n < DEPTH; n++) begin
            chk($sformatf("of_drain%0d", n), m_data_o, wdata(n));
            tick();
        end
        m_ready_i = 1'b0;
        chk("of_empty", 32'(m_valid_o), 32'd0);
        chk("of_sticky", 32'(overflow_o), 32'd1);

        // synchronous-to-edge reset clears overflow
        rst_i = 1'b1;
        #1;
        chk("rst2_ovf", 32'(overflow_o), 32'd0);
        tick();
        rst_i = 1'b0;

        // full FIFO with simultaneous push and pop
        for (int n = 10; n < 10 + DEPTH; n++) begin
            push_word(n);
        end
        chk("sp_full", 32'(level_o), 32'(DEPTH));
        send(wbyte(30, 0));
        send(wbyte(30, 1));
        send(wbyte(30, 2));
        m_ready_i = 1'b1;
        send(wbyte(30, 3));
        m_ready_i = 1'b0;
        chk("sp_level", 32'(level_o), 32'(DEPTH));
        chk("sp_ovf", 32'(overflow_o), 32'd0);
        m_ready_i = 1'b1;
        for (int n = 11; n < 10 + DEPTH; n++) begin
            chk($sformatf("sp_drain%0d", n), m_data_o, wdata(n));
            tick();
        end
        chk("sp_newlast", m_data_o, wdata(30));
        tick();
        m_ready_i = 1'b0;
        chk("sp_empty", 32'(level_o), 32'd0);

        // async reset between edges with staged bytes and queued words
        for (int n = 40; n < 43; n++) begin
            push_word(n);
        end
        send(8'hC1);
        send(8'hC2);
        chk("ar_pre", 32'(level_o), 32'd3);
        #2;
        rst_i = 1'b1;
        #1;
        chk("ar_valid", 32'(m_valid_o), 32'd0);
        chk("ar_data", m_data_o, 32'd0);
        chk("ar_level", 32'(level_o), 32'd0);
        tick();
        rst_i = 1'b0;
        push_word(50);
        chk("ar_one", 32'(level_o), 32'd1);
        chk("ar_data2", m_data_o, wdata(50));
        chk("ar_keep2", 32'(m_keep_o), 32'hF);
        tick();
        tick();
        chk("ar_stable", 32'(level_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
